// File: rtl/uart_frame_assembler_pkg.sv
// Shared types and helpers for the UART frame assembler: state encoding,
// default sync marker and frame-width helper.
package uart_frame_assembler_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int unsigned frameWidth(input int unsigned frameBytes);
        return 8 * frameBytes;
    endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out bus between the UART receiver side and the frame consumer.
interface uart_frame_assembler_if #(
    parameter int unsigned W = 80
);
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic [W-1:0] frame;
    logic         frame_valid;
    logic         err_checksum;
    logic         err_timeout;
    logic [15:0]  good_count;

    modport master (
        output byte_data, byte_valid,
        input  frame, frame_valid, err_checksum, err_timeout, good_count
    );

    modport slave (
        input  byte_data, byte_valid,
        output frame, frame_valid, err_checksum, err_timeout, good_count
    );
endinterface

// File: rtl/uart_frame_assembler_byte_timeout_timer.sv
// Idle-cycle watchdog: counts cycles without a kick while enabled and flags
// expiry on the cycle the count sits at its terminal value with no kick.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 208340
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Held at zero while disabled so every frame starts with a fresh budget
    always_ff @(posedge clk) begin
        if (reset || !enable || kick) begin
            count <= '0;
        end else if (count != TERMINAL) begin
            count <= count + TW'(1);
        end
    end

    assign expired = enable && !kick && (count == TERMINAL);

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts for a sync byte, collects FRAME_BYTES payload bytes, verifies an XOR
// checksum byte and publishes the frame (optionally bit-reversed).
module uart_frame_assembler
    import uart_frame_assembler_pkg::*;
#(
    parameter int unsigned FRAME_BYTES    = 10,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 208340,
    parameter bit          REVERSE        = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_frame_assembler_if.slave  bus
);
    localparam int unsigned W     = frameWidth(FRAME_BYTES);
    localparam int unsigned IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t           state, stateNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [7:0]       chk, chkNext;
    logic [W-1:0]     shadow, shadowNext;
    logic [W-1:0]     frameReg, frameNext;
    logic [W-1:0]     reversed, frameOrdered;
    logic             frameValid, frameValidNext;
    logic             errChecksum, errChecksumNext;
    logic             errTimeout, errTimeoutNext;
    logic [15:0]      goodCount, goodCountNext;
    logic             timerEnable, timerKick, timerExpired;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (timerEnable),
        .kick    (timerKick),
        .expired (timerExpired)
    );

    for (genvar i = 0; i < W; i++) begin : gRev
        assign reversed[i] = shadow[W-1-i];
    end

    assign frameOrdered = REVERSE ? reversed : shadow;
    assign timerEnable  = (state == COLLECT) || (state == CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            idx         <= '0;
            chk         <= '0;
            shadow      <= '0;
            frameReg    <= '0;
            frameValid  <= 1'b0;
            errChecksum <= 1'b0;
            errTimeout  <= 1'b0;
            goodCount   <= '0;
        end else begin
            state       <= stateNext;
            idx         <= idxNext;
            chk         <= chkNext;
            shadow      <= shadowNext;
            frameReg    <= frameNext;
            frameValid  <= frameValidNext;
            errChecksum <= errChecksumNext;
            errTimeout  <= errTimeoutNext;
            goodCount   <= goodCountNext;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        stateNext       = state;
        idxNext         = idx;
        chkNext         = chk;
        shadowNext      = shadow;
        frameNext       = frameReg;
        frameValidNext  = 1'b0;
        errChecksumNext = 1'b0;
        errTimeoutNext  = 1'b0;
        goodCountNext   = goodCount;
        timerKick       = 1'b0;

        case (state)
            HUNT: begin
                if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
                    stateNext = COLLECT;
                    idxNext   = '0;
                    chkNext   = '0;
                    timerKick = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.byte_valid) begin
                    shadowNext[32'(idx) * 8 +: 8] = bus.byte_data;
                    chkNext   = chk ^ bus.byte_data;
                    idxNext   = idx + IDX_W'(1);
                    timerKick = 1'b1;
                    if (idx == LAST_IDX) begin
                        stateNext = CHECK;
                    end
                end else if (timerExpired) begin
                    errTimeoutNext = 1'b1;
                    stateNext      = HUNT;
                end
            end
            CHECK: begin
                if (bus.byte_valid) begin
                    timerKick = 1'b1;
                    stateNext = HUNT;
                    if (bus.byte_data == chk) begin
                        frameNext      = frameOrdered;
                        frameValidNext = 1'b1;
                        goodCountNext  = goodCount + 16'd1;
                    end else begin
                        errChecksumNext = 1'b1;
                    end
                end else if (timerExpired) begin
                    errTimeoutNext = 1'b1;
                    stateNext      = HUNT;
                end
            end
            default: begin
                stateNext = HUNT;
            end
        endcase
    end

    assign bus.frame        = frameReg;
    assign bus.frame_valid  = frameValid;
    assign bus.err_checksum = errChecksum;
    assign bus.err_timeout  = errTimeout;
    assign bus.good_count   = goodCount;

endmodule
